// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the RAM sequencer.
//   state_t   - sequencer states
//   WAIT_BITS - width of the read wait counter (READ_WAIT range 0..15)
package mem_ctrl_pkg;

  localparam int unsigned WAIT_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    W_SETUP,
    W_STROBE,
    W_HOLD
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequencer between the core's single-beat load/store requests and
// the asynchronous-strobe RAM.
//   clk, reset_n                      - clock, synchronous active-low reset
//   req_valid/req_ready               - request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata       - request: 1 = store, address, store data
//   rsp_valid, rsp_rdata              - one-cycle done pulse, held load data
//   ram_address, ram_data             - RAM address, shared tristate data bus
//   ram_out_en, ram_write_en          - RAM read enable, write strobe
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned READ_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic [ADDR_BITS-1:0] ram_address,
  inout  wire  [DATA_BITS-1:0] ram_data,
  output logic                 ram_out_en,
  output logic                 ram_write_en
);

  if (READ_WAIT > 15) begin : g_bad_read_wait
    $error("mem_ctrl: READ_WAIT must be in 0..15");
  end

  state_t                 state, state_next;
  logic [WAIT_BITS-1:0]   cnt, cnt_next;
  logic [DATA_BITS-1:0]   wdata_q;
  logic                   drive_en;
  logic                   accept;
  logic                   capture;
  logic                   done;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Bus is driven only from a register, so it changes solely on clock edges.
  assign ram_data = drive_en ? wdata_q : 'z;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = req_we ? W_SETUP : RD;
          cnt_next   = req_we ? '0 : WAIT_BITS'(READ_WAIT);
        end
      end
      RD: begin
        if (cnt != '0) begin
          cnt_next = cnt - WAIT_BITS'(1);
        end else begin
          capture    = 1'b1;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      W_SETUP:  state_next = W_STROBE;
      W_STROBE: state_next = W_HOLD;
      W_HOLD: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // RAM-side outputs are decoded from the next state and registered, so they
  // line up with the state they belong to without any combinational glitch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      ram_address  <= '0;
      ram_out_en   <= 1'b0;
      ram_write_en <= 1'b0;
      drive_en     <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      rsp_valid    <= done;
      ram_out_en   <= (state_next == RD);
      ram_write_en <= (state_next == W_STROBE);
      drive_en     <= (state_next inside {W_SETUP, W_STROBE, W_HOLD});
      if (accept) begin
        ram_address <= req_addr;
      end
      if (capture) begin
        rsp_rdata <= ram_data;
      end
    end
  end

  // Store data is pure datapath; it only reaches the bus through drive_en.
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_q <= req_wdata;
    end
  end

endmodule
